// File: rtl/addressdecode_cycle_ctrl_if.sv
// Dock I/O cycle-control bus: CPU/tile strobes in, qualified cycle signals out.
interface addressdecode_cycle_ctrl_if;
  logic cpu_iorq_n;
  logic cpu_r_w_;
  logic tile_ready_n;
  logic iorq_n;
  logic is_read;
  logic is_write;
  logic cpu_wait_n;
  logic timeout;
  logic busy;

  modport master (
    output cpu_iorq_n, cpu_r_w_, tile_ready_n,
    input  iorq_n, is_read, is_write, cpu_wait_n, timeout, busy
  );

  modport slave (
    input  cpu_iorq_n, cpu_r_w_, tile_ready_n,
    output iorq_n, is_read, is_write, cpu_wait_n, timeout, busy
  );
endinterface

// File: rtl/addressdecode_cycle_ctrl.sv
// Synchronises CPU I/O strobes, detects cycle start and holds the CPU in wait
// states until the tile is ready or a bounded timeout expires.
module addressdecode_cycle_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_WAIT    = 1,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input logic                       clk,
  input logic                       rst,
  addressdecode_cycle_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, WAIT, HOLD} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(MIN_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(TIMEOUT_CYC);

  // lanes: [2]=iorq_n, [1]=r_w_, [0]=ready_n
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [SYNC_STAGES:0]        vld_pipe_q;
  logic                        iorq_s, rw_s, rdy_s, iorq_prev_q;
  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_inc;
  logic                        dir_q, dir_d;
  logic iorq_n_q, is_read_q, is_write_q, wait_n_q, timeout_q, busy_q;
  logic iorq_n_d, is_read_d, is_write_d, wait_n_d, timeout_d, busy_d;

  assign {iorq_s, rw_s, rdy_s} = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '1;
      vld_pipe_q  <= '0;
      iorq_prev_q <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      iorq_n_q    <= 1'b1;
      is_read_q   <= 1'b0;
      is_write_q  <= 1'b0;
      wait_n_q    <= 1'b1;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], {bus.cpu_iorq_n, bus.cpu_r_w_, bus.tile_ready_n}};
      vld_pipe_q  <= {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
      iorq_prev_q <= iorq_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      iorq_n_q    <= iorq_n_d;
      is_read_q   <= is_read_d;
      is_write_q  <= is_write_d;
      wait_n_q    <= wait_n_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    timeout_d = 1'b0;
    unique case (state_q)
      // The preset sync chain fakes a high level after reset; an edge only
      // counts once the previous-cycle sample is real input data.
      IDLE: if (vld_pipe_q[SYNC_STAGES] && iorq_prev_q && !iorq_s) begin
        state_d = SETUP;
        dir_d   = rw_s;
        cnt_d   = '0;
      end
      SETUP: begin
        if (iorq_s) state_d = IDLE;
        else if (cnt_q == SETUP_LAST) begin
          // The exit edge doubles as the first ready check, so an already
          // ready tile costs no WAIT cycles.
          cnt_d   = '0;
          state_d = rdy_s ? WAIT : HOLD;
        end else cnt_d = cnt_inc;
      end
      WAIT: begin
        if (iorq_s) state_d = IDLE;
        else if (!rdy_s) state_d = HOLD;
        else begin
          cnt_d = cnt_inc;
          if (TIMEOUT_CYC != 0 && cnt_inc == TO_LIMIT) begin
            state_d   = HOLD;
            timeout_d = 1'b1;
          end
        end
      end
      HOLD: if (iorq_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    iorq_n_d   = (state_d == IDLE);
    is_read_d  = busy_d && dir_d;
    is_write_d = busy_d && !dir_d;
    wait_n_d   = !(state_d == SETUP || state_d == WAIT);
  end

  assign bus.iorq_n     = iorq_n_q;
  assign bus.is_read    = is_read_q;
  assign bus.is_write   = is_write_q;
  assign bus.cpu_wait_n = wait_n_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;
endmodule
